// File: rtl/mc_pkg.sv
// rtl/mc_pkg.sv - shared scan controller state encoding and default widths
package mc_pkg;

  localparam int POS_W_DEFAULT    = 11;
  localparam int SETTLE_W_DEFAULT = 16;
  localparam int TMO_W_DEFAULT    = 20;

  typedef enum logic [2:0] {
    IDLE,
    GREQ,
    SETTLE,
    PGO,
    PWAIT,
    ADV
  } scan_state_t;

endpackage

// File: rtl/scan_axis_counter.sv
// rtl/scan_axis_counter.sv - grid index plus wrapping position accumulator for one scan axis
module scan_axis_counter
  import mc_pkg::*;
#(
  parameter int W = POS_W_DEFAULT
) (
  input  logic         clk_control,
  input  logic         rst_control_n,
  input  logic         load,
  input  logic         restart,
  input  logic         inc,
  input  logic         dec,
  input  logic [W-1:0] start_pos,
  input  logic [W-1:0] step,
  input  logic [W-1:0] count,
  output logic [W-1:0] idx,
  output logic [W-1:0] pos,
  output logic         at_last
);

  logic [W-1:0] start_q;
  logic [W-1:0] step_q;
  logic [W-1:0] last_q;

  // load captures the frame geometry so mid-frame input changes are invisible
  always_ff @(posedge clk_control or negedge rst_control_n) begin
    if (!rst_control_n) begin
      start_q <= '0;
      step_q  <= '0;
      last_q  <= '0;
      idx     <= '0;
      pos     <= '0;
    end else if (load) begin
      start_q <= start_pos;
      step_q  <= step;
      last_q  <= (count == '0) ? '0 : count - W'(1);
      idx     <= '0;
      pos     <= start_pos;
    end else if (restart) begin
      idx <= '0;
      pos <= start_q;
    end else if (inc) begin
      idx <= idx + W'(1);
      pos <= pos + step_q;
    end else if (dec) begin
      idx <= idx - W'(1);
      pos <= pos - step_q;
    end
  end

  assign at_last = (idx == last_q);

endmodule

// File: rtl/scan_sequencer.sv
// rtl/scan_sequencer.sv - 2-D galvo grid scan FSM; SCAN_SERPENTINE_EN selects boustrophedon rows
module scan_sequencer
  import mc_pkg::*;
#(
  parameter int POS_W    = POS_W_DEFAULT,
  parameter int SETTLE_W = SETTLE_W_DEFAULT,
  parameter int TMO_W    = TMO_W_DEFAULT
) (
  input  logic                clk_control,
  input  logic                rst_control_n,
  input  logic                start,
  input  logic                abort,
  input  logic [POS_W-1:0]    h_start,
  input  logic [POS_W-1:0]    v_start,
  input  logic [POS_W-1:0]    h_step,
  input  logic [POS_W-1:0]    v_step,
  input  logic [POS_W-1:0]    h_count,
  input  logic [POS_W-1:0]    v_count,
  input  logic [SETTLE_W-1:0] settle_cycles,
  input  logic [TMO_W-1:0]    timeout_cycles,
  input  logic                err_clr,
  output logic                galvo_req,
  output logic [POS_W-1:0]    galvo_h,
  output logic [POS_W-1:0]    galvo_v,
  input  logic                galvo_ack,
  output logic                pixel_go,
  input  logic                pixel_done,
  output logic                busy,
  output logic                frame_done,
  output logic                timeout_err,
  output logic [POS_W-1:0]    cur_col,
  output logic [POS_W-1:0]    cur_row
);

`ifdef SCAN_SERPENTINE_EN
  localparam bit SERP = 1'b1;
`else
  localparam bit SERP = 1'b0;
`endif

  scan_state_t         state, state_next;
  logic [SETTLE_W-1:0] settle_q, settle_cnt;
  logic [TMO_W-1:0]    tmo_q, tmo_cnt;
  logic cfg_load, h_restart, h_inc, h_dec, v_inc, last_pixel, tmo_fire;
  logic h_last, v_last, odd_row, row_end;

  scan_axis_counter #(.W(POS_W)) u_h_axis (
    .clk_control   (clk_control),
    .rst_control_n (rst_control_n),
    .load          (cfg_load),
    .restart       (h_restart),
    .inc           (h_inc),
    .dec           (h_dec),
    .start_pos     (h_start),
    .step          (h_step),
    .count         (h_count),
    .idx           (cur_col),
    .pos           (galvo_h),
    .at_last       (h_last)
  );

  scan_axis_counter #(.W(POS_W)) u_v_axis (
    .clk_control   (clk_control),
    .rst_control_n (rst_control_n),
    .load          (cfg_load),
    .restart       (1'b0),
    .inc           (v_inc),
    .dec           (1'b0),
    .start_pos     (v_start),
    .step          (v_step),
    .count         (v_count),
    .idx           (cur_row),
    .pos           (galvo_v),
    .at_last       (v_last)
  );

  // odd rows run right-to-left only in serpentine builds
  assign odd_row = SERP && cur_row[0];
  assign row_end = odd_row ? (cur_col == '0) : h_last;

  always_ff @(posedge clk_control or negedge rst_control_n) begin
    if (!rst_control_n) state <= IDLE;
    else                state <= state_next;
  end

  always_comb begin
    state_next = state;
    cfg_load   = 1'b0;
    h_restart  = 1'b0;
    h_inc      = 1'b0;
    h_dec      = 1'b0;
    v_inc      = 1'b0;
    last_pixel = 1'b0;
    tmo_fire   = 1'b0;
    case (state)
      IDLE: if (start) begin
        cfg_load   = 1'b1;
        state_next = GREQ;
      end
      GREQ:   if (galvo_ack) state_next = (settle_q == '0) ? PGO : SETTLE;
      SETTLE: if (settle_cnt == SETTLE_W'(1)) state_next = PGO;
      PGO:    state_next = PWAIT;
      PWAIT: begin
        if (pixel_done) begin
          state_next = ADV;
        end else if (tmo_q != '0 && tmo_cnt == TMO_W'(1)) begin
          tmo_fire   = 1'b1;
          state_next = IDLE;
        end
      end
      ADV: begin
        state_next = GREQ;
        if (!row_end) begin
          h_inc = !odd_row;
          h_dec = odd_row;
        end else begin
          h_restart = !SERP;
          v_inc     = 1'b1;
          if (v_last) begin
            last_pixel = 1'b1;
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
    if (abort) begin
      state_next = IDLE;
      cfg_load   = 1'b0;
      h_restart  = 1'b0;
      h_inc      = 1'b0;
      h_dec      = 1'b0;
      v_inc      = 1'b0;
      last_pixel = 1'b0;
      tmo_fire   = 1'b0;
    end
  end

  always_ff @(posedge clk_control or negedge rst_control_n) begin
    if (!rst_control_n) begin
      settle_q    <= '0;
      tmo_q       <= '0;
      settle_cnt  <= '0;
      tmo_cnt     <= '0;
      frame_done  <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      frame_done <= last_pixel;
      if (cfg_load) begin
        settle_q <= settle_cycles;
        tmo_q    <= timeout_cycles;
      end
      if (state == GREQ)        settle_cnt <= settle_q;
      else if (state == SETTLE) settle_cnt <= settle_cnt - SETTLE_W'(1);
      if (state == PGO)         tmo_cnt <= tmo_q;
      else if (state == PWAIT)  tmo_cnt <= tmo_cnt - TMO_W'(1);
      // a timeout in the same cycle as err_clr must stay visible
      if (tmo_fire)     timeout_err <= 1'b1;
      else if (err_clr) timeout_err <= 1'b0;
    end
  end

  assign galvo_req = (state == GREQ);
  assign pixel_go  = (state == PGO);
  assign busy      = (state != IDLE);

endmodule
